// File: rtl/axi_sub_mem.sv
// AXI4 subordinate memory: answers INCR/FIXED write and read bursts from a
// word array, with independent write and read state machines.
module axi_sub_mem #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast
);

  localparam int          LSB   = $clog2(AXI_STRB_WIDTH);
  localparam int          DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned STRB  = AXI_STRB_WIDTH;

  typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     init_done;

  idx_t                    w_idx;
  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [7:0]              w_len, w_beat;
  logic                    w_fixed, w_err;

  idx_t                    r_idx, rd_addr;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [7:0]              r_len, r_beat;
  logic                    r_fixed, r_load;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_final, w_last_bad, r_final;

  assign aw_hs      = s_axi_awvalid && s_axi_awready;
  assign w_hs       = s_axi_wvalid && s_axi_wready;
  assign b_hs       = s_axi_bvalid && s_axi_bready;
  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign r_hs       = s_axi_rvalid && s_axi_rready;
  assign w_final    = w_hs && (w_beat == w_len);
  assign w_last_bad = s_axi_wlast != (w_beat == w_len);
  assign r_final    = r_hs && (r_beat == r_len);

  assign s_axi_bid   = w_id;
  assign s_axi_rid   = r_id;
  assign s_axi_rresp = 2'b00;

  // Size and the upper address bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize,
                       s_axi_awburst, s_axi_arburst};

  // Holds both idle-ready outputs low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      w_state       <= w_next;
      s_axi_awready <= init_done && (w_next == W_IDLE);
      s_axi_wready  <= (w_next == W_DATA);
      s_axi_bvalid  <= (w_next == W_RESP);
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)   w_next = W_DATA;
      W_DATA:  if (w_final) w_next = W_RESP;
      W_RESP:  if (b_hs)    w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_idx       <= '0;
      w_id        <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_fixed     <= 1'b0;
      w_err       <= 1'b0;
      s_axi_bresp <= 2'b00;
    end else begin
      if (aw_hs) begin
        w_idx   <= s_axi_awaddr[MEM_ADDR_WIDTH+LSB-1:LSB];
        w_id    <= s_axi_awid;
        w_len   <= s_axi_awlen;
        w_fixed <= (s_axi_awburst == 2'b00);
        w_beat  <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        if (w_last_bad) w_err <= 1'b1;
        if (!w_fixed)   w_idx <= w_idx + idx_t'(1);
      end
      if (w_final)   s_axi_bresp <= (w_err || w_last_bad) ? 2'b10 : 2'b00;
      else if (b_hs) s_axi_bresp <= 2'b00;
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= init_done && (r_next == R_IDLE);
      s_axi_rvalid  <= (r_next == R_DATA);
    end
  end

  always_comb begin
    r_next  = r_state;
    r_load  = 1'b0;
    rd_addr = r_idx;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: begin
        r_next = R_DATA;
        r_load = 1'b1;
      end
      R_DATA: begin
        if (r_final) begin
          r_next = R_IDLE;
        end else if (r_hs) begin
          r_load  = 1'b1;
          rd_addr = r_fixed ? r_idx : r_idx + idx_t'(1);
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // The next beat is fetched on the accepting edge so rdata only changes
  // on a handshake and stays put while the manager stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_id        <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_fixed     <= 1'b0;
      s_axi_rlast <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_idx   <= s_axi_araddr[MEM_ADDR_WIDTH+LSB-1:LSB];
        r_id    <= s_axi_arid;
        r_len   <= s_axi_arlen;
        r_fixed <= (s_axi_arburst == 2'b00);
        r_beat  <= '0;
      end
      if (r_hs) r_beat <= r_beat + 8'd1;
      if (r_load) begin
        r_idx       <= rd_addr;
        s_axi_rlast <= (r_state == R_FETCH) ? (r_len == 8'd0)
                                            : ((r_beat + 8'd1) == r_len);
      end else if (r_final) begin
        s_axi_rlast <= 1'b0;
      end
    end
  end

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && w_hs) begin
      for (int unsigned i = 0; i < STRB; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
    if (r_load) s_axi_rdata <= mem[rd_addr];
  end

endmodule

// File: doc/axi_sub_mem.md
# axi_sub_mem

AXI4 subordinate memory: the responder end of the AXI manager tester, answering its INCR write and read bursts from a block-RAM array. Write and read channels run independent state machines, each with one outstanding transaction. Sits between an AXI manager (tester, arbiter output) and nothing else; it is the simulation and FPGA stand-in for external SRAM.

## Interface
- AXI_ADDR_WIDTH, 20, byte address width
- AXI_DATA_WIDTH, 16, data width (multiple of 8)
- AXI_ID_WIDTH, 4, ID width
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width
- MEM_ADDR_WIDTH, 8, log2 of memory depth in words
- clk  in  1  clock
- rst_n  in  1  reset rst_n, synchronous, active-low; clock clk
- s_axi_aw{valid,ready,addr,id,len,size,burst}: valid in 1, ready out 1, addr in AXI_ADDR_WIDTH, id in AXI_ID_WIDTH, len in 8, size in 3, burst in 2
- s_axi_w{valid,ready,data,strb,last}: valid in 1, ready out 1, data in AXI_DATA_WIDTH, strb in AXI_STRB_WIDTH, last in 1
- s_axi_b{valid,ready,id,resp}: valid out 1, ready in 1, id out AXI_ID_WIDTH, resp out 2
- s_axi_ar{valid,ready,addr,id,len,size,burst}: as AW
- s_axi_r{valid,ready,data,id,resp,last}: valid out 1, ready in 1, data out AXI_DATA_WIDTH, id out AXI_ID_WIDTH, resp out 2, last out 1

## Operation
- Word index = addr[MEM_ADDR_WIDTH+LSB-1:LSB], LSB = log2(AXI_STRB_WIDTH); upper address bits ignored (aliasing); unaligned low bits dropped.
- Each beat advances the word index by 1, modulo 2^MEM_ADDR_WIDTH. burst=FIXED (2'b00): index constant. INCR and WRAP (01/10): incrementing; WRAP is not supported and behaves as INCR. size ignored; full-width beats assumed.
- Write FSM: W_IDLE (awready=1) -> AW handshake latches index, id, len, clears beat count and error flag -> W_DATA (wready=1). Each W handshake writes bytes where strb=1. wlast must equal (beat == len); any mismatch sets the error flag. After beat len accepted -> W_RESP (bvalid=1, bid=latched id, bresp=2'b00 or 2'b10 SLVERR if error flag). B handshake -> W_IDLE. Burst length is always len+1; wlast never terminates early.
- Read FSM: R_IDLE (arready=1) -> AR handshake latches index, id, len -> R_DATA. RAM read synchronous, one cycle. rdata held stable while rvalid && !rready. rlast=1 on beat len only. rresp always 2'b00, rid=latched id. After final R handshake -> R_IDLE.
- Simultaneous write and read of same word in one cycle: read returns old data.
- Memory contents not reset and not initialised.

## Timing
- During reset and cycle after: all valid/ready outputs 0, bresp/rresp 0, rlast 0. awready and arready are 1 from the second cycle after rst_n rises; all ready/valid outputs registered.
- AW handshake cycle N: wready=1 from N+1. Write throughput one beat/cycle while wvalid=1.
- Last W handshake cycle M: bvalid=1 at M+1. B handshake cycle K: awready=1 at K+1.
- AR handshake cycle N: first rvalid at N+2. With rready held 1, beats back-to-back, rlast at N+2+len. rready low stalls: no beat dropped, duplicated, or reordered.
- Last R handshake cycle K: arready=1 at K+1.
- Reset mid-burst: both FSMs to idle next edge, outstanding transaction discarded, bvalid/rvalid drop.

## Test plan
- 8 write bursts of 3 beats (len=2) at byte addr 0,6,12,...,42, data 0xD0..0xE7 -> bresp 00 each; 8 read bursts same addrs return 0xD0..0xE7 in order, rlast on every 3rd beat, rid=arid.
- Read len=3 with rready pattern 1,0,0,1,1,0,1 -> 4 beats delivered exactly once each in order, rdata stable while stalled, first rvalid 2 cycles after AR.
- Word 0x1111 then write 0xABCD with wstrb 2'b01 -> read 0x11CD; wstrb 2'b10 -> 0xAB11.
- Write len=3 with wlast on beat 1 -> 4 beats accepted, bresp 2'b10; next burst with correct wlast -> bresp 2'b00.
- MEM_ADDR_WIDTH=4, INCR len=3 from word 14 -> words 14,15,0,1 written/read; FIXED len=2 -> only final beat remains at that word.
- rst_n low during W_DATA beat 1 and R_DATA beat 1 -> bvalid/rvalid/wready 0 next cycle, awready/arready 1 after release, fresh burst completes correctly.
